// File: rtl/tmpram_readout_scheduler_if.sv
// RAM port-B and output-stream signals shared by the readout scheduler and its neighbours.
// master = scheduler side; slave = RAM/attention side.
interface tmpram_readout_scheduler_if #(
  parameter int DATA_W = 128,
  parameter int OUT_W  = 64,
  parameter int ADDR_W = 13
);
  logic              o_grant;
  logic [ADDR_W-1:0] o_rd_addr;
  logic [DATA_W-1:0] i_ram00_doutb;
  logic [DATA_W-1:0] i_ram01_doutb;
  logic              o_data_valid;
  logic              i_data_ready;
  logic [OUT_W-1:0]  o_fmap;
  logic [OUT_W-1:0]  o_patchdata;

  modport master (
    output o_grant, o_rd_addr, o_data_valid, o_fmap, o_patchdata,
    input  i_ram00_doutb, i_ram01_doutb, i_data_ready
  );

  modport slave (
    input  o_grant, o_rd_addr, o_data_valid, o_fmap, o_patchdata,
    output i_ram00_doutb, i_ram01_doutb, i_data_ready
  );
endinterface

// File: rtl/tmpram_readout_scheduler.sv
// Streams NUM_WORDS words from both TmpRams to the attention part; first word RD_LAT+2 cycles after the start edge.
// Reads are credit-limited by a FIFO_DEPTH output FIFO, so downstream stalls never drop or duplicate words.
module tmpram_readout_scheduler #(
  parameter int DATA_W     = 128,
  parameter int OUT_W      = 64,
  parameter int ADDR_W     = 13,
  parameter int NUM_WORDS  = 3072,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        s_clk,
  input  logic                        s_rst,
  input  logic                        i_start,
  input  logic                        SPS_part_done,
  tmpram_readout_scheduler_if.master  rd_if,
  output logic                        o_busy,
  output logic                        o_done
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + RD_LAT + 1) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t             state, state_nx;
  logic               start_q;
  logic [ADDR_W-1:0]  rd_addr;
  logic [RD_LAT-1:0]  vld_sr;
  logic [2*OUT_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   fifo_cnt, inflight;
  logic               grant_q, busy_q, done_q;
  logic               fifo_vld, push, pop, start_edge, issue, last_issue, drain_empty;
  logic [2*OUT_W-1:0] head;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + CNT_W'(vld_sr[i]);
  end

  assign fifo_vld   = (fifo_cnt != '0);
  assign pop        = fifo_vld && rd_if.i_data_ready;
  assign push       = vld_sr[RD_LAT-1];
  assign start_edge = i_start && !start_q;
  // Words already in the RAM pipeline hold a FIFO slot, so a push can never find the FIFO full without a pop.
  assign issue      = (state == READ) && !SPS_part_done && ((inflight + fifo_cnt) < CNT_W'(FIFO_DEPTH));
  assign last_issue = issue && (rd_addr == LAST_ADDR);
  assign drain_empty = (vld_sr == '0) && ((fifo_cnt == '0) || ((fifo_cnt == CNT_W'(1)) && pop));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_edge)  state_nx = READ;
      READ:    if (last_issue)  state_nx = DRAIN;
      DRAIN:   if (drain_empty) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
    if (SPS_part_done) state_nx = IDLE;
  end

  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      state    <= IDLE;
      start_q  <= 1'b0;
      rd_addr  <= '0;
      vld_sr   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      grant_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      start_q <= i_start;
      grant_q <= (state_nx == READ) || (state_nx == DRAIN);
      busy_q  <= (state_nx != IDLE);
      done_q  <= (state_nx == DONE);
      if (SPS_part_done) begin
        rd_addr  <= '0;
        vld_sr   <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        fifo_cnt <= '0;
      end else begin
        if ((state == IDLE) && start_edge)
          rd_addr <= '0;
        else if (issue && !last_issue)
          rd_addr <= rd_addr + ADDR_W'(1);
        vld_sr <= (vld_sr << 1) | RD_LAT'(issue);
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  always_ff @(posedge s_clk) begin
    if (push && !SPS_part_done)
      fifo_mem[wr_ptr] <= {rd_if.i_ram01_doutb[OUT_W-1:0], rd_if.i_ram00_doutb[OUT_W-1:0]};
  end

  assert property (@(posedge s_clk) disable iff (s_rst)
    (push && (fifo_cnt == CNT_W'(FIFO_DEPTH))) |-> pop);

  assign head               = fifo_mem[rd_ptr];
  assign rd_if.o_grant      = grant_q;
  assign rd_if.o_rd_addr    = rd_addr;
  assign rd_if.o_data_valid = fifo_vld;
  assign rd_if.o_fmap       = fifo_vld ? head[OUT_W-1:0] : '0;
  assign rd_if.o_patchdata  = fifo_vld ? head[2*OUT_W-1:OUT_W] : '0;
  assign o_busy             = busy_q;
  assign o_done             = done_q;

  generate
    if (DATA_W > OUT_W) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^{rd_if.i_ram00_doutb[DATA_W-1:OUT_W], rd_if.i_ram01_doutb[DATA_W-1:OUT_W]};
    end
  endgenerate
endmodule

// File: tb/tb_tmpram_readout_scheduler.sv
// Random-ready bench for tmpram_readout_scheduler: expected stream is word index 0..NUM_WORDS-1 per pass,
// data from a RAM model, timing and abort/reset behaviour checked against the block's rules.
module tb_tmpram_readout_scheduler;
  localparam int DATA_W = 128, OUT_W = 64, ADDR_W = 13, NUM_WORDS = 16, RD_LAT = 2, DEPTH = 4;

  logic s_clk = 1'b0;
  logic s_rst, i_start, SPS_part_done, o_busy, o_done;
  always #5 s_clk = ~s_clk;

  tmpram_readout_scheduler_if #(.DATA_W(DATA_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W)) rd_if ();

  tmpram_readout_scheduler #(
    .DATA_W(DATA_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W),
    .NUM_WORDS(NUM_WORDS), .RD_LAT(RD_LAT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .s_clk(s_clk), .s_rst(s_rst), .i_start(i_start), .SPS_part_done(SPS_part_done),
    .rd_if(rd_if), .o_busy(o_busy), .o_done(o_done)
  );

  function automatic logic [63:0] f0(input int a);
    return 64'h5A5A_0000_0000_0000 | 64'(a);
  endfunction
  function automatic logic [63:0] f1(input int a);
    return 64'hC3C3_0000_0000_0000 | (64'(a) * 64'd7 + 64'd3);
  endfunction

  // RAM model: two-cycle read, upper half junk that must never reach the outputs
  logic [ADDR_W-1:0] ram_a_d1;
  always @(posedge s_clk) begin
    ram_a_d1            <= rd_if.o_rd_addr;
    rd_if.i_ram00_doutb <= {64'hFFFF_EEEE_DDDD_CCCC, f0(int'(ram_a_d1))};
    rd_if.i_ram01_doutb <= {64'h1234_5678_9ABC_DEF0, f1(int'(ram_a_d1))};
  end

  int n_cmp = 0, n_err = 0;
  int words = 0, last_words = 0, done_total = 0, max_out = 0;
  int ready_mode = 0;
  logic ready_hold = 1'b0;
  logic prev_stall = 1'b0, prev_sps = 1'b0, prev_busy = 1'b0;
  logic [63:0] prev_fmap = '0;
  logic s_valid, s_done, s_grant, s_busy;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic monitor();
    int outstanding;
    s_valid = rd_if.o_data_valid; s_done = o_done; s_grant = rd_if.o_grant; s_busy = o_busy;
    if (s_rst) begin
      prev_stall = 1'b0; prev_busy = 1'b0; words = 0;
      return;
    end
    if (prev_stall && !prev_sps) begin
      chk("head_hold_valid", 64'(rd_if.o_data_valid), 64'd1);
      chk("head_hold_data", rd_if.o_fmap, prev_fmap);
    end
    if (rd_if.o_grant) begin
      outstanding = int'(rd_if.o_rd_addr) - words;
      if (outstanding > max_out) max_out = outstanding;
    end
    if (!rd_if.o_data_valid)
      chk("zero_when_invalid", rd_if.o_fmap | rd_if.o_patchdata, 64'd0);
    else if (rd_if.i_data_ready) begin
      chk("fmap_word", rd_if.o_fmap, f0(words));
      chk("patch_word", rd_if.o_patchdata, f1(words));
      words++;
    end
    if (o_done) done_total++;
    if (prev_busy && !o_busy) last_words = words;
    if (!o_busy) words = 0;
    prev_stall = rd_if.o_data_valid && !rd_if.i_data_ready;
    prev_fmap  = rd_if.o_fmap;
    prev_sps   = SPS_part_done;
    prev_busy  = o_busy;
  endtask

  task automatic step();
    @(negedge s_clk);
    monitor();
    @(posedge s_clk);
    #1;
    case (ready_mode)
      1:       rd_if.i_data_ready = !rd_if.i_data_ready;
      2:       rd_if.i_data_ready = 1'($urandom_range(0, 1));
      default: rd_if.i_data_ready = ready_hold;
    endcase
  endtask

  task automatic start_pass();
    i_start = 1'b0;
    step();
    i_start = 1'b1;
    step();
  endtask

  task automatic run_pass(input int budget);
    bit seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      step();
      if (s_done) seen = 1'b1;
    end
    chk("done_seen", 64'(seen), 64'd1);
    step();
    chk("pass_words", 64'(last_words), 64'(NUM_WORDS));
  endtask

  initial begin
    int first_v, done_k, done_pulses, vcnt, base;
    logic g1, g19, g21;
    s_rst = 1'b1; i_start = 1'b0; SPS_part_done = 1'b0; rd_if.i_data_ready = 1'b0;
    repeat (3) step();
    #3 s_rst = 1'b0;
    step();
    chk("rst_grant", 64'(rd_if.o_grant), 0);
    chk("rst_valid", 64'(rd_if.o_data_valid), 0);
    chk("rst_busy_done", 64'({o_busy, o_done}), 0);
    chk("rst_addr", 64'(rd_if.o_rd_addr), 0);

    // 1: ready high, exact latency
    ready_mode = 0; ready_hold = 1'b1;
    step();
    i_start = 1'b1;
    first_v = -1; done_k = -1; done_pulses = 0; vcnt = 0; g1 = 0; g19 = 0; g21 = 1;
    for (int k = 0; k < 26; k++) begin
      step();
      if (s_valid && first_v < 0) first_v = k;
      if (s_valid) vcnt++;
      if (s_done) begin done_pulses++; done_k = k; end
      if (k == 1)  g1 = s_grant;
      if (k == 19) g19 = s_grant;
      if (k == 21) g21 = s_grant;
    end
    chk("t1_first_valid_cycle", 64'(first_v), 64'd4);
    chk("t1_done_cycle", 64'(done_k), 64'd20);
    chk("t1_done_pulses", 64'(done_pulses), 64'd1);
    chk("t1_valid_cycles", 64'(vcnt), 64'(NUM_WORDS));
    chk("t1_grant_first_read", 64'(g1), 64'd1);
    chk("t1_grant_drain", 64'(g19), 64'd1);
    chk("t1_grant_low_after", 64'(g21), 64'd0);
    chk("t1_words", 64'(last_words), 64'(NUM_WORDS));
    chk("t1_no_retrigger", 64'(s_busy), 64'd0);

    // 2: ready toggling
    max_out = 0; ready_mode = 1;
    start_pass();
    run_pass(200);
    chk("t2_outstanding_le_depth", 64'(max_out <= DEPTH), 64'd1);

    // 3: long stall after start
    max_out = 0; ready_mode = 0; ready_hold = 1'b0;
    start_pass();
    repeat (50) step();
    chk("t3_addr_held", 64'(rd_if.o_rd_addr), 64'd4);
    chk("t3_fifo_valid", 64'(rd_if.o_data_valid), 64'd1);
    chk("t3_head_word0", rd_if.o_fmap, f0(0));
    chk("t3_outstanding", 64'(max_out), 64'(DEPTH));
    ready_hold = 1'b1;
    run_pass(200);

    // 4: abort mid-stream with FIFO occupied
    ready_hold = 1'b1;
    start_pass();
    for (int n = 0; n < 100 && words < 7; n++) step();
    chk("t4_reach_word7", 64'(words), 64'd7);
    ready_hold = 1'b0;
    step(); step();
    chk("t4_fifo_occupied", 64'(rd_if.o_data_valid), 64'd1);
    base = done_total;
    SPS_part_done = 1'b1;
    step();
    SPS_part_done = 1'b0;
    chk("t4_abort_valid", 64'(rd_if.o_data_valid), 64'd0);
    chk("t4_abort_grant", 64'(rd_if.o_grant), 64'd0);
    chk("t4_abort_busy", 64'(o_busy), 64'd0);
    repeat (5) step();
    chk("t4_no_done", 64'(done_total), 64'(base));
    ready_hold = 1'b1;
    start_pass();
    run_pass(200);

    // 5: start and abort together, then start edge while busy
    i_start = 1'b0; step();
    i_start = 1'b1; SPS_part_done = 1'b1;
    step();
    SPS_part_done = 1'b0;
    step(); step();
    chk("t5_stays_idle", 64'(s_busy), 64'd0);
    base = done_total;
    start_pass();
    repeat (3) step();
    i_start = 1'b0; step();
    i_start = 1'b1; step();
    run_pass(200);
    repeat (5) step();
    chk("t5_single_done", 64'(done_total), 64'(base + 1));
    chk("t5_idle_after", 64'(s_busy), 64'd0);

    // 6: async reset mid-read
    start_pass();
    repeat (6) step();
    #3 s_rst = 1'b1; i_start = 1'b0;
    #1;
    chk("t6_rst_valid_grant", 64'({rd_if.o_data_valid, rd_if.o_grant}), 64'd0);
    chk("t6_rst_busy_done", 64'({o_busy, o_done}), 64'd0);
    chk("t6_rst_data", rd_if.o_fmap | rd_if.o_patchdata, 64'd0);
    chk("t6_rst_addr", 64'(rd_if.o_rd_addr), 64'd0);
    step(); step();
    #3 s_rst = 1'b0;
    repeat (5) step();
    chk("t6_idle_after_rst", 64'(s_busy), 64'd0);
    start_pass();
    run_pass(200);

    // 7: random ready, random gaps between passes
    max_out = 0; ready_mode = 2;
    for (int p = 0; p < 3; p++) begin
      repeat ($urandom_range(0, 4)) step();
      start_pass();
      run_pass(400);
    end
    chk("t7_outstanding_le_depth", 64'(max_out <= DEPTH), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
